// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation codes and the default iteration count.
package muldiv_pkg;

    localparam int DEFAULT_ITERS = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the magnitude datapath.
// MULT: shift-add step on {hi, lo}, lo holding the remaining multiplier bits.
// DIV : restoring step; {hi, lo} shifts left, hi is the partial remainder,
//       quotient bits enter lo from the right.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             op_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sh_lo;
    logic             ge;

    // The shifted remainder is {hi[WIDTH-1], sh_lo}; when its top bit is set it
    // always exceeds the divisor, and the true difference then fits WIDTH bits.
    assign sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    assign sh_lo = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign ge    = hi[WIDTH-1] | (sh_lo >= operand);

    // Select the shift-add or restore-subtract result.
    always_comb begin
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
        if (op_div) begin
            hi_nxt = ge ? (sh_lo - operand) : sh_lo;
            lo_nxt = {lo[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide sequencer producing HI/LO results.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; operands captured on start
//   LOAD    | magnitudes loaded into accumulators, counter cleared
//   RUN     | one datapath iteration per cycle, WIDTH cycles
//   FIX     | sign correction, hi_out/lo_out registered (skipped on div/0)
//   DONE    | one-cycle completion pulse with write strobes
//
// Divide-by-zero passes LOAD -> FIX -> DONE without iterating, so its done
// pulse lands two edges after the start edge and results are left untouched.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ITERS
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             HI_reg_w,
    output logic             LO_reg_w
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_acc, lo_acc;
    logic [WIDTH-1:0]   a_mag, b_mag, hi_nxt, lo_nxt;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic               op_q, dz_q, div_by_zero, neg_res;

    assign a_mag       = a_q[WIDTH-1] ? -a_q : a_q;
    assign b_mag       = b_q[WIDTH-1] ? -b_q : b_q;
    assign div_by_zero = (op_q == OP_DIV) && (b_q == '0);
    assign neg_res     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign prod_fix    = neg_res ? -{hi_acc, lo_acc} : {hi_acc, lo_acc};
    assign quo_fix     = neg_res ? -lo_acc : lo_acc;
    assign rem_fix     = a_q[WIDTH-1] ? -hi_acc : hi_acc;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .op_div  (op_q),
        .hi      (hi_acc),
        .lo      (lo_acc),
        .operand (op_q == OP_DIV ? b_mag : a_mag),
        .hi_nxt  (hi_nxt),
        .lo_nxt  (lo_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and Moore outputs; strobes exist only in DONE.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        done     = 1'b0;
        div_zero = 1'b0;
        HI_reg_w = 1'b0;
        LO_reg_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = div_by_zero ? ST_FIX : ST_RUN;
            ST_RUN:  if (cnt_q == LAST_ITER) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: begin
                done     = 1'b1;
                div_zero = dz_q;
                HI_reg_w = !dz_q;
                LO_reg_w = !dz_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath, counter and result registers.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_MULT;
            dz_q   <= 1'b0;
            hi_acc <= '0;
            lo_acc <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q  <= a_in;
                        b_q  <= b_in;
                        op_q <= op_div;
                        dz_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    cnt_q  <= '0;
                    dz_q   <= div_by_zero;
                    hi_acc <= '0;
                    lo_acc <= (op_q == OP_DIV) ? a_mag : b_mag;
                end
                ST_RUN: begin
                    cnt_q  <= cnt_q + 1'b1;
                    hi_acc <= hi_nxt;
                    lo_acc <= lo_nxt;
                end
                ST_FIX: begin
                    if (!dz_q) begin
                        if (op_q == OP_DIV) begin
                            hi_out <= rem_fix;
                            lo_out <= quo_fix;
                        end else begin
                            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_out <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer at WIDTH=32.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_in, start, op_div;
    logic [31:0] a_in, b_in;
    logic        busy, done, div_zero, HI_reg_w, LO_reg_w;
    logic [31:0] hi_out, lo_out;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .start    (start),
        .op_div   (op_div),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .HI_reg_w (HI_reg_w),
        .LO_reg_w (LO_reg_w)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_in = 1'b1; start = 1'b1; op_div = 1'b0; a_in = 32'd9; b_in = 32'd9;
        tick; tick;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (div_zero !== 1'b0)  begin bad++; $display("FAIL reset_div_zero got=%0b exp=0", div_zero); end
        total++; if (HI_reg_w !== 1'b0)  begin bad++; $display("FAIL reset_hi_w got=%0b exp=0", HI_reg_w); end
        total++; if (LO_reg_w !== 1'b0)  begin bad++; $display("FAIL reset_lo_w got=%0b exp=0", LO_reg_w); end
        total++; if (hi_out !== 32'h0)   begin bad++; $display("FAIL reset_hi got=%h exp=0", hi_out); end
        total++; if (lo_out !== 32'h0)   begin bad++; $display("FAIL reset_lo got=%h exp=0", lo_out); end
        reset_in = 1'b0; start = 1'b0;
        tick;
    endtask

    task automatic test_mult;
        int early = 0, idle = 0;
        op_div = 1'b0; a_in = 32'd7; b_in = 32'hFFFF_FFFD; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            tick;
            if (done | div_zero | HI_reg_w | LO_reg_w) early++;
            if (!busy) idle++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL mult_early_done got=%0d exp=0", early); end
        total++; if (idle != 0)  begin bad++; $display("FAIL mult_busy_drop got=%0d exp=0", idle); end
        tick;
        total++; if (done !== 1'b1)      begin bad++; $display("FAIL mult_done got=%0b exp=1", done); end
        total++; if (HI_reg_w !== 1'b1)  begin bad++; $display("FAIL mult_hi_w got=%0b exp=1", HI_reg_w); end
        total++; if (LO_reg_w !== 1'b1)  begin bad++; $display("FAIL mult_lo_w got=%0b exp=1", LO_reg_w); end
        total++; if (div_zero !== 1'b0)  begin bad++; $display("FAIL mult_div_zero got=%0b exp=0", div_zero); end
        total++; if (hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi_out); end
        total++; if (lo_out !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo_out); end
        tick;
        total++; if (done !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL mult_after got done=%0b busy=%0b exp 0 0", done, busy); end
    endtask

    task automatic test_div;
        int early = 0;
        op_div = 1'b1; a_in = 32'hFFFF_FFF9; b_in = 32'd2; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            tick;
            if (done | div_zero | HI_reg_w | LO_reg_w) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL div_early_done got=%0d exp=0", early); end
        tick;
        total++; if (done !== 1'b1)     begin bad++; $display("FAIL div_done got=%0b exp=1", done); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div_div_zero got=%0b exp=0", div_zero); end
        total++; if (lo_out !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_quo got=%h exp=fffffffd", lo_out); end
        total++; if (hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_rem got=%h exp=ffffffff", hi_out); end
        tick;
    endtask

    task automatic test_div_zero;
        op_div = 1'b1; a_in = 32'd5; b_in = 32'd0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL dz_done_early got=%0b exp=0", done); end
        tick;
        total++; if (done !== 1'b1)     begin bad++; $display("FAIL dz_done got=%0b exp=1", done); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%0b exp=1", div_zero); end
        total++; if (HI_reg_w !== 1'b0 || LO_reg_w !== 1'b0)
            begin bad++; $display("FAIL dz_strobes got=%0b%0b exp=00", HI_reg_w, LO_reg_w); end
        total++; if (hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_hi_kept got=%h exp=ffffffff", hi_out); end
        total++; if (lo_out !== 32'hFFFF_FFFD) begin bad++; $display("FAIL dz_lo_kept got=%h exp=fffffffd", lo_out); end
        tick;
        total++; if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL dz_after got done=%0b dz=%0b busy=%0b exp 0 0 0", done, div_zero, busy); end
    endtask

    task automatic test_div_overflow;
        op_div = 1'b1; a_in = 32'h8000_0000; b_in = 32'hFFFF_FFFF; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 34; i++) tick;
        total++; if (done !== 1'b1)     begin bad++; $display("FAIL ovf_done got=%0b exp=1", done); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL ovf_div_zero got=%0b exp=0", div_zero); end
        total++; if (lo_out !== 32'h8000_0000) begin bad++; $display("FAIL ovf_quo got=%h exp=80000000", lo_out); end
        total++; if (hi_out !== 32'h0)         begin bad++; $display("FAIL ovf_rem got=%h exp=0", hi_out); end
        tick;
    endtask

    task automatic test_reset_abort;
        int early = 0;
        op_div = 1'b0; a_in = 32'd5; b_in = 32'd5; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick;
            if (done) early++;
        end
        reset_in = 1'b1;
        tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0 || HI_reg_w !== 1'b0 || LO_reg_w !== 1'b0)
            begin bad++; $display("FAIL abort_strobes got done=%0b hw=%0b lw=%0b exp 0 0 0", done, HI_reg_w, LO_reg_w); end
        total++; if (hi_out !== 32'h0 || lo_out !== 32'h0)
            begin bad++; $display("FAIL abort_results got=%h_%h exp=0_0", hi_out, lo_out); end
        reset_in = 1'b0;
        a_in = 32'h0001_0000; b_in = 32'h0001_0000; start = 1'b1;
        tick;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_restart_busy got=%0b exp=1", busy); end
        for (int i = 1; i <= 33; i++) begin
            tick;
            if (done | HI_reg_w | LO_reg_w) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL abort_spurious_done got=%0d exp=0", early); end
        tick;
        total++; if (done !== 1'b1)       begin bad++; $display("FAIL abort_mult_done got=%0b exp=1", done); end
        total++; if (hi_out !== 32'h1)    begin bad++; $display("FAIL abort_mult_hi got=%h exp=1", hi_out); end
        total++; if (lo_out !== 32'h0)    begin bad++; $display("FAIL abort_mult_lo got=%h exp=0", lo_out); end
        tick;
    endtask

    task automatic test_ignore_start;
        int early = 0, idle = 0;
        op_div = 1'b0; a_in = 32'd3; b_in = 32'd4; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 6; i++) tick;
        op_div = 1'b1; a_in = 32'd100; b_in = 32'd100; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 8; i <= 33; i++) begin
            tick;
            if (done) early++;
            if (!busy) idle++;
        end
        total++; if (early != 0 || idle != 0)
            begin bad++; $display("FAIL ign_timing got early=%0d idle=%0d exp 0 0", early, idle); end
        tick;
        total++; if (done !== 1'b1)    begin bad++; $display("FAIL ign_done got=%0b exp=1", done); end
        total++; if (hi_out !== 32'h0) begin bad++; $display("FAIL ign_hi got=%h exp=0", hi_out); end
        total++; if (lo_out !== 32'd12) begin bad++; $display("FAIL ign_lo got=%h exp=c", lo_out); end
        op_div = 1'b0; a_in = 32'd9; b_in = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_start_in_done got busy=%0b exp=0", busy); end
        tick;
        total++; if (busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL ign_stay_idle got busy=%0b done=%0b exp 0 0", busy, done); end
    endtask

    initial begin
        reset_in = 1'b1; start = 1'b0; op_div = 1'b0; a_in = '0; b_in = '0;
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_div_overflow;
        test_reset_abort;
        test_ignore_start;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
